// File: rtl/addsub_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for the add/sub accumulator.
package addsub_pkg;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_CLR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;
   localparam int FLAG_W = 4;

endpackage

// File: rtl/addsub_flags.sv
// Combinational W-bit add/subtract with carry and signed-overflow detection.
// Saturation on overflow is built in when ADDSUB_ACC_SAT_EN is defined.
module addsub_flags
   import addsub_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [1:0]   op_i,
   input  logic [W-1:0] acc_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] res_o,
   output logic         c_o,
   output logic         v_o
);

   logic         m;
   logic [W-1:0] b_x;
   logic [W-1:0] sum;
   logic         carry;
   logic         ovf;

`ifdef ADDSUB_ACC_SAT_EN
   localparam logic signed [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

   // Overflow direction follows the accumulator sign: an overflowing result
   // always has the opposite sign of acc, so acc tells which limit to clamp to.
   function automatic logic [W-1:0] saturate(input logic [W-1:0] raw,
                                             input logic         of,
                                             input logic         neg);
      if (!of)
         return raw;
      return neg ? SAT_NEG : SAT_POS;
   endfunction
`endif

   always_comb begin
      m            = (op_i == OP_SUB);
      b_x          = data_i ^ {W{m}};
      {carry, sum} = {1'b0, acc_i} + {1'b0, b_x} + {{W{1'b0}}, m};
      // Same rule serves ADD and SUB because b_x is the effective addend.
      ovf          = (acc_i[W-1] == b_x[W-1]) && (sum[W-1] != acc_i[W-1]);

      res_o = '0;
      c_o   = 1'b0;
      v_o   = 1'b0;
      case (op_i)
         OP_LOAD: res_o = data_i;
         OP_ADD, OP_SUB: begin
`ifdef ADDSUB_ACC_SAT_EN
            res_o = saturate(sum, ovf, acc_i[W-1]);
`else
            res_o = sum;
`endif
            c_o   = carry;
            v_o   = ovf;
         end
         default: res_o = '0;
      endcase
   end

endmodule

// File: rtl/addsub_acc_ctrl.sv
// Handshaked accumulator stage: IDLE accepts a request, EXEC updates acc and flags,
// RESP presents the result until taken. Optional saturation: ADDSUB_ACC_SAT_EN.
module addsub_acc_ctrl
   import addsub_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   in_op,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_acc,
   output logic         out_c,
   output logic         out_z,
   output logic         out_n,
   output logic         out_v
);

   localparam logic [FLAG_W-1:0] FLAGS_RST = FLAG_W'(1) << FLAG_Z;

   state_e              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [W-1:0]        data_q, data_d;
   logic [W-1:0]        acc_q, acc_d;
   logic [FLAG_W-1:0]   flags_q, flags_d;

   logic [W-1:0]        res;
   logic                res_c;
   logic                res_v;

   addsub_flags #(.W(W)) u_flags (
      .op_i   (op_q),
      .acc_i  (acc_q),
      .data_i (data_q),
      .res_o  (res),
      .c_o    (res_c),
      .v_o    (res_v)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_LOAD;
         data_q  <= '0;
         acc_q   <= '0;
         flags_q <= FLAGS_RST;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         acc_q   <= acc_d;
         flags_q <= flags_d;
      end
   end

   // Handshake outputs depend on state only, never on in_valid/out_ready.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      data_d    = data_q;
      acc_d     = acc_q;
      flags_d   = flags_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               op_d    = in_op;
               data_d  = in_data;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            acc_d           = res;
            flags_d[FLAG_C] = res_c;
            flags_d[FLAG_Z] = (res == '0);
            flags_d[FLAG_N] = res[W-1];
            flags_d[FLAG_V] = res_v;
            state_d         = ST_RESP;
         end
         ST_RESP: begin
            out_valid = 1'b1;
            if (out_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign out_acc = acc_q;
   assign out_c   = flags_q[FLAG_C];
   assign out_z   = flags_q[FLAG_Z];
   assign out_n   = flags_q[FLAG_N];
   assign out_v   = flags_q[FLAG_V];

endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// Self-checking bench for addsub_acc_ctrl: directed vector table, multi-cycle
// corner sequences and random transactions against an arithmetic reference model.
module tb_addsub_acc_ctrl;

   localparam int W   = 4;
   localparam int LIM = 1 << W;

   localparam logic [1:0] T_LOAD = 2'b00;
   localparam logic [1:0] T_ADD  = 2'b01;
   localparam logic [1:0] T_SUB  = 2'b10;
   localparam logic [1:0] T_CLR  = 2'b11;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   in_op = 2'b00;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_acc;
   logic         out_c, out_z, out_n, out_v;

   int n_chk = 0;
   int n_err = 0;

   int   m_acc = 0;
   logic m_c = 1'b0, m_z = 1'b1, m_n = 1'b0, m_v = 1'b0;

   typedef struct packed {
      logic [1:0]   op;
      logic [W-1:0] data;
      logic [W-1:0] acc;
      logic         c, z, n, v;
   } vec_t;

   vec_t tbl[17];

   always #5 clk = ~clk;

   addsub_acc_ctrl #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_c     (out_c),
      .out_z     (out_z),
      .out_n     (out_n),
      .out_v     (out_v)
   );

   function automatic vec_t mk(input logic [1:0] op, input int d, input int a,
                               input logic c, input logic z, input logic n, input logic v);
      vec_t r;
      r.op = op; r.data = W'(d); r.acc = W'(a);
      r.c = c; r.z = z; r.n = n; r.v = v;
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string nm, input int a, input logic c, input logic z,
                          input logic n, input logic v);
      chk({nm, ".acc"}, int'(out_acc), a);
      chk({nm, ".c"}, int'(out_c), int'(c));
      chk({nm, ".z"}, int'(out_z), int'(z));
      chk({nm, ".n"}, int'(out_n), int'(n));
      chk({nm, ".v"}, int'(out_v), int'(v));
   endtask

   // Reference model: plain unsigned/signed integer arithmetic.
   task automatic model_apply(input logic [1:0] op, input int d);
      int sa, sd, sr, r;
      sa = (m_acc >= LIM / 2) ? m_acc - LIM : m_acc;
      sd = (d >= LIM / 2) ? d - LIM : d;
      sr = 0;
      case (op)
         T_LOAD: begin r = d; m_c = 1'b0; end
         T_CLR:  begin r = 0; m_c = 1'b0; end
         T_ADD:  begin r = m_acc + d; m_c = (r >= LIM); sr = sa + sd; end
         default: begin r = m_acc - d + LIM; m_c = (m_acc >= d); sr = sa - sd; end
      endcase
      m_v = (op == T_ADD || op == T_SUB) && (sr > LIM / 2 - 1 || sr < -(LIM / 2));
      m_acc = r % LIM;
`ifdef ADDSUB_ACC_SAT_EN
      if (m_v) m_acc = (sr > 0) ? LIM / 2 - 1 : LIM / 2;
`endif
      m_z = (m_acc == 0);
      m_n = (m_acc >= LIM / 2);
   endtask

   task automatic issue(input logic [1:0] op, input logic [W-1:0] d);
      int k;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_data = d;
      k = 0;
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Counts negedges after the accept edge until out_valid is seen.
   task automatic wait_resp(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) chk("exec_in_ready", int'(in_ready), 0);
      end while (!out_valid && lat < 10);
      if (!out_valid) chk("resp_timeout", 0, 1);
      chk("resp_in_ready", int'(in_ready), 0);
   endtask

   task automatic finish_resp();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [1:0] op;
      logic [W-1:0] d;
      int stall;
      logic [W-1:0] held;

      tbl[0]  = mk(T_LOAD, 8, 8, 0, 0, 1, 0);
`ifdef ADDSUB_ACC_SAT_EN
      tbl[1]  = mk(T_SUB, 2, 8, 1, 0, 1, 1);
`else
      tbl[1]  = mk(T_SUB, 2, 6, 1, 0, 0, 1);
`endif
      tbl[2]  = mk(T_LOAD, 8, 8, 0, 0, 1, 0);
      tbl[3]  = mk(T_ADD, 2, 10, 0, 0, 1, 0);
      tbl[4]  = mk(T_LOAD, 10, 10, 0, 0, 1, 0);
`ifdef ADDSUB_ACC_SAT_EN
      tbl[5]  = mk(T_ADD, 13, 8, 1, 0, 1, 1);
`else
      tbl[5]  = mk(T_ADD, 13, 7, 1, 0, 0, 1);
`endif
      tbl[6]  = mk(T_LOAD, 10, 10, 0, 0, 1, 0);
      tbl[7]  = mk(T_SUB, 13, 13, 0, 0, 1, 0);
      tbl[8]  = mk(T_CLR, 5, 0, 0, 1, 0, 0);
      tbl[9]  = mk(T_ADD, 15, 15, 0, 0, 1, 0);
      tbl[10] = mk(T_ADD, 1, 0, 1, 1, 0, 0);
      tbl[11] = mk(T_LOAD, 7, 7, 0, 0, 0, 0);
`ifdef ADDSUB_ACC_SAT_EN
      tbl[12] = mk(T_ADD, 1, 7, 0, 0, 0, 1);
`else
      tbl[12] = mk(T_ADD, 1, 8, 0, 0, 1, 1);
`endif
      tbl[13] = mk(T_LOAD, 0, 0, 0, 1, 0, 0);
      tbl[14] = mk(T_SUB, 1, 15, 0, 0, 1, 0);
      tbl[15] = mk(T_LOAD, 8, 8, 0, 0, 1, 0);
`ifdef ADDSUB_ACC_SAT_EN
      tbl[16] = mk(T_SUB, 1, 8, 1, 0, 1, 1);
`else
      tbl[16] = mk(T_SUB, 1, 7, 1, 0, 0, 1);
`endif

      // reset state
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_out("reset", 0, 0, 1, 0, 0);
      chk("reset.out_valid", int'(out_valid), 0);
      chk("reset.in_ready", int'(in_ready), 1);
      rst_n = 1'b1;

      // directed vector table
      for (int i = 0; i < 17; i++) begin
         issue(tbl[i].op, tbl[i].data);
         model_apply(tbl[i].op, int'(tbl[i].data));
         wait_resp(lat);
         chk($sformatf("tbl%0d.latency", i), lat, 2);
         chk_out($sformatf("tbl%0d", i), int'(tbl[i].acc), tbl[i].c, tbl[i].z, tbl[i].n, tbl[i].v);
         finish_resp();
      end

      // backpressure with a pending request held on the input
      issue(T_LOAD, 4'd5);
      model_apply(T_LOAD, 5);
      wait_resp(lat);
      in_valid = 1'b1; in_op = T_ADD; in_data = 4'd3;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("bp%0d.out_valid", k), int'(out_valid), 1);
         chk($sformatf("bp%0d.in_ready", k), int'(in_ready), 0);
         chk($sformatf("bp%0d.acc", k), int'(out_acc), 5);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("bp.idle_in_ready", int'(in_ready), 1);
      chk("bp.idle_out_valid", int'(out_valid), 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      model_apply(T_ADD, 3);
      @(negedge clk);
      chk("bp.exec_in_ready", int'(in_ready), 0);
      chk("bp.exec_out_valid", int'(out_valid), 0);
      @(negedge clk);
      chk("bp.resp_out_valid", int'(out_valid), 1);
      chk_out("bp.result", m_acc, m_c, m_z, m_n, m_v);
      finish_resp();

      // reset in the middle of EXEC
      issue(T_LOAD, 4'd6);
      model_apply(T_LOAD, 6);
      wait_resp(lat);
      finish_resp();
      issue(T_ADD, 4'd3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_out("midrst", 0, 0, 1, 0, 0);
      chk("midrst.out_valid", int'(out_valid), 0);
      chk("midrst.in_ready", int'(in_ready), 1);
      repeat (2) begin
         @(negedge clk);
         chk("midrst.hold_valid", int'(out_valid), 0);
      end
      rst_n = 1'b1;
      m_acc = 0; m_c = 1'b0; m_z = 1'b1; m_n = 1'b0; m_v = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("postrst.out_valid", int'(out_valid), 0);
         chk("postrst.acc", int'(out_acc), 0);
      end
      issue(T_ADD, 4'd3);
      model_apply(T_ADD, 3);
      wait_resp(lat);
      chk_out("postrst.add", m_acc, m_c, m_z, m_n, m_v);
      finish_resp();

      // randomized transactions, random out_ready timing
      for (int t = 0; t < 150; t++) begin
         op = 2'($urandom_range(0, 3));
         d  = W'($urandom_range(0, LIM - 1));
         out_ready = 1'($urandom_range(0, 1));
         issue(op, d);
         model_apply(op, int'(d));
         wait_resp(lat);
         chk($sformatf("rnd%0d.latency", t), lat, 2);
         chk_out($sformatf("rnd%0d", t), m_acc, m_c, m_z, m_n, m_v);
         if (!out_ready) begin
            stall = $urandom_range(0, 3);
            held = out_acc;
            for (int k = 0; k < stall; k++) begin
               @(negedge clk);
               chk($sformatf("rnd%0d.stall_valid", t), int'(out_valid), 1);
               chk($sformatf("rnd%0d.stall_acc", t), int'(out_acc), int'(held));
            end
         end
         finish_resp();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
